// File: rtl/output_port_if.sv
// Flit/credit types shared by the router, plus the bundle of link-side
// signals that connect the crossbar and downstream router to output_port.
//
// noc_params      : flit_label_t (HEAD/BODY/TAIL/HEADTAIL) and flit_t.
// output_port_if  : valid_i/flit_i/vc_i    flit offered by the crossbar
//                   credit_valid_i/_vc_i   credit returned from downstream
//                   valid_o/flit_o/vc_o    registered flit on the link
//                   credit_avail_o         per-VC "credits > 0"
//                   vc_free_o              per-VC "VC is IDLE"
//                   error_o                one-cycle protocol-violation pulse
//   modport slave  : the output_port side
//   modport master : the crossbar/downstream side (or a testbench)

package noc_params;
   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef struct packed {
      flit_label_t flit_label;
      logic [15:0] data;
   } flit_t;
endpackage

interface output_port_if #(parameter int VC_NUM = 2) ();
   import noc_params::*;

   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   logic              valid_i;
   flit_t             flit_i;
   logic [VC_W-1:0]   vc_i;
   logic              credit_valid_i;
   logic [VC_W-1:0]   credit_vc_i;
   logic              valid_o;
   flit_t             flit_o;
   logic [VC_W-1:0]   vc_o;
   logic [VC_NUM-1:0] credit_avail_o;
   logic [VC_NUM-1:0] vc_free_o;
   logic              error_o;

   modport slave (
      input  valid_i, flit_i, vc_i, credit_valid_i, credit_vc_i,
      output valid_o, flit_o, vc_o, credit_avail_o, vc_free_o, error_o
   );

   modport master (
      output valid_i, flit_i, vc_i, credit_valid_i, credit_vc_i,
      input  valid_o, flit_o, vc_o, credit_avail_o, vc_free_o, error_o
   );
endinterface

// File: rtl/output_port.sv
// Router output port: credit-based flow control towards the downstream
// input port, one packet-tracking FSM per virtual channel, and a
// registered flit stage onto the link.
//
// Ports:
//   clk     : single clock, rising edge
//   rst     : asynchronous, active-high reset
//   port_if : output_port_if.slave (see rtl/output_port_if.sv)
//
// Parameters:
//   VC_NUM      : virtual channels on the outgoing link
//   BUFFER_SIZE : downstream per-VC buffer depth (initial credits per VC)

module output_port
   import noc_params::*;
#(
   parameter int VC_NUM      = 2,
   parameter int BUFFER_SIZE = 8
) (
   input  logic         clk,
   input  logic         rst,
   output_port_if.slave port_if
);

   localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAINING} vc_state_t;

   logic [CNT_W-1:0] credit_q [VC_NUM];
   logic [CNT_W-1:0] credit_d [VC_NUM];
   vc_state_t        state_q  [VC_NUM];
   vc_state_t        state_d  [VC_NUM];

   logic            accept;
   logic            error_d;
   logic [VC_NUM-1:0] acc_v;
   logic [VC_NUM-1:0] ret_v;

   logic            valid_q;
   flit_t           flit_q;
   logic [VC_W-1:0] vc_q;
   logic            error_q;

   flit_label_t label;
   assign label = port_if.flit_i.flit_label;

   // State register: credit counters and per-VC FSMs.
   // NOTE: these arrays are only VC_NUM entries of control state, so they are
   // reset like ordinary flops; a reset-free RAM style would leave the credit
   // counts undefined after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            credit_q[v] <= FULL;
            state_q[v]  <= IDLE;
         end
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            credit_q[v] <= credit_d[v];
            state_q[v]  <= state_d[v];
         end
      end
   end

   // Next-state logic: accept decision, credit arithmetic, FSM transitions
   // and the merged error condition.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      accept  = port_if.valid_i && (credit_q[port_if.vc_i] != '0);
      // A flit offered with no credit is dropped and flagged.
      error_d = port_if.valid_i && !accept;
      acc_v   = '0;
      ret_v   = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         acc_v[v]    = accept && (port_if.vc_i == VC_W'(v));
         ret_v[v]    = port_if.credit_valid_i && (port_if.credit_vc_i == VC_W'(v));
         credit_d[v] = credit_q[v];
         state_d[v]  = state_q[v];

         // Accept and return on the same VC cancel out.
         if (acc_v[v] && !ret_v[v]) begin
            credit_d[v] = credit_q[v] - 1'b1;
         end else if (ret_v[v] && !acc_v[v]) begin
            if (credit_q[v] == FULL) error_d = 1'b1;   // credit overflow, hold
            else                     credit_d[v] = credit_q[v] + 1'b1;
         end

         // Violating labels are still forwarded; only the FSM ignores them.
         if (acc_v[v]) begin
            unique case (state_q[v])
               IDLE: begin
                  if      (label == HEAD)     state_d[v] = ACTIVE;
                  else if (label == HEADTAIL) state_d[v] = DRAINING;
                  else                        error_d = 1'b1;
               end
               ACTIVE, DRAINING: begin
                  if (label == HEAD || label == HEADTAIL) error_d = 1'b1;
                  else if (state_q[v] == ACTIVE && label == TAIL)
                     state_d[v] = DRAINING;
               end
               default: state_d[v] = IDLE;
            endcase
         end

         // Packet fully drained once every downstream slot is free again,
         // judged on the count this edge will load.
         if (state_q[v] == DRAINING && credit_d[v] == FULL) state_d[v] = IDLE;
      end
   end

   // Output logic: allocator status from registered state only.
   always_comb begin
      port_if.credit_avail_o = '0;
      port_if.vc_free_o      = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         port_if.credit_avail_o[v] = (credit_q[v] != '0);
         port_if.vc_free_o[v]      = (state_q[v] == IDLE);
      end
   end

   // Registered link stage; flit_o/vc_o hold their last value when idle.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         flit_q  <= '0;
         vc_q    <= '0;
         error_q <= 1'b0;
      end else begin
         valid_q <= accept;
         error_q <= error_d;
         if (accept) begin
            flit_q <= port_if.flit_i;
            vc_q   <= port_if.vc_i;
         end
      end
   end

   assign port_if.valid_o = valid_q;
   assign port_if.flit_o  = flit_q;
   assign port_if.vc_o    = vc_q;
   assign port_if.error_o = error_q;

endmodule

// File: tb/tb_output_port.sv
// Directed self-checking bench for output_port (VC_NUM=2, BUFFER_SIZE=8).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the following rising edge.

module tb_output_port;
   import noc_params::*;

   localparam int ST_IDLE = 0, ST_ACTIVE = 1, ST_DRAINING = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_port_if #(.VC_NUM(2)) bus ();

   output_port #(.VC_NUM(2), .BUFFER_SIZE(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .port_if (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic flit_t mk(input flit_label_t l, input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.data       = d;
      return f;
   endfunction

   task automatic drive(input logic v, input flit_label_t l, input logic [15:0] d,
                        input logic vc, input logic cv, input logic cvc);
      bus.valid_i        = v;
      bus.flit_i         = mk(l, d);
      bus.vc_i           = vc;
      bus.credit_valid_i = cv;
      bus.credit_vc_i    = cvc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check("rst_valid", 32'(bus.valid_o), 0);
      check("rst_flit", 32'(bus.flit_o), 0);
      check("rst_error", 32'(bus.error_o), 0);
      check("rst_avail", 32'(bus.credit_avail_o), 2'b11);
      check("rst_free", 32'(bus.vc_free_o), 2'b11);
      check("rst_cnt0", 32'(dut.credit_q[0]), 8);
      rst = 1'b0;
      step();
      check("post_rst_valid", 32'(bus.valid_o), 0);

      // HEAD, BODY, TAIL on VC0
      drive(1'b1, HEAD, 16'h0011, 1'b0, 1'b0, 1'b0);
      step();
      check("p1_head_valid", 32'(bus.valid_o), 1);
      check("p1_head_flit", 32'(bus.flit_o), 32'(mk(HEAD, 16'h0011)));
      check("p1_head_vc", 32'(bus.vc_o), 0);
      check("p1_head_free", 32'(bus.vc_free_o), 2'b10);
      drive(1'b1, BODY, 16'h0022, 1'b0, 1'b0, 1'b0);
      step();
      check("p1_body_flit", 32'(bus.flit_o), 32'(mk(BODY, 16'h0022)));
      check("p1_body_state", 32'(dut.state_q[0]), ST_ACTIVE);
      drive(1'b1, TAIL, 16'h0033, 1'b0, 1'b0, 1'b0);
      step();
      check("p1_tail_valid", 32'(bus.valid_o), 1);
      check("p1_tail_flit", 32'(bus.flit_o), 32'(mk(TAIL, 16'h0033)));
      check("p1_cnt0", 32'(dut.credit_q[0]), 5);
      check("p1_state", 32'(dut.state_q[0]), ST_DRAINING);
      check("p1_error", 32'(bus.error_o), 0);
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("p1_idle_valid", 32'(bus.valid_o), 0);
      check("p1_hold_flit", 32'(bus.flit_o), 32'(mk(TAIL, 16'h0033)));

      // Return three credits on VC0: back to 8, IDLE on the last edge
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b1, 1'b0);
      step();
      step();
      check("ret_cnt0_7", 32'(dut.credit_q[0]), 7);
      check("ret_free_busy", 32'(bus.vc_free_o[0]), 0);
      step();
      check("ret_cnt0_8", 32'(dut.credit_q[0]), 8);
      check("ret_free", 32'(bus.vc_free_o[0]), 1);
      check("ret_error", 32'(bus.error_o), 0);

      // Exhaust VC1 with HEAD, 6 BODY, TAIL
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY), 16'(16'h0100 + i),
               1'b1, 1'b0, 1'b0);
         step();
         check($sformatf("vc1_valid_%0d", i), 32'(bus.valid_o), 1);
         check($sformatf("vc1_cnt_%0d", i), 32'(dut.credit_q[1]), 32'(7 - i));
      end
      check("vc1_vc_o", 32'(bus.vc_o), 1);
      check("vc1_avail", 32'(bus.credit_avail_o), 2'b01);
      drive(1'b1, BODY, 16'h0199, 1'b1, 1'b0, 1'b0);
      step();
      check("drop_valid", 32'(bus.valid_o), 0);
      check("drop_error", 32'(bus.error_o), 1);
      check("drop_cnt1", 32'(dut.credit_q[1]), 0);
      check("drop_flit_hold", 32'(bus.flit_o), 32'(mk(TAIL, 16'h0107)));
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("drop_error_clr", 32'(bus.error_o), 0);

      // HEADTAIL on VC0, then one credit return
      drive(1'b1, HEADTAIL, 16'h0AAA, 1'b0, 1'b0, 1'b0);
      step();
      check("ht_state", 32'(dut.state_q[0]), ST_DRAINING);
      check("ht_cnt0", 32'(dut.credit_q[0]), 7);
      check("ht_free", 32'(bus.vc_free_o[0]), 0);
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b1, 1'b0);
      step();
      check("ht_ret_state", 32'(dut.state_q[0]), ST_IDLE);
      check("ht_ret_free", 32'(bus.vc_free_o[0]), 1);
      check("ht_ret_cnt0", 32'(dut.credit_q[0]), 8);

      // Bring VC0 to 5 mid-packet, then simultaneous accept/return
      drive(1'b1, HEAD, 16'h0201, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, BODY, 16'h0202, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, BODY, 16'h0203, 1'b0, 1'b0, 1'b0);
      step();
      check("sim_pre_cnt0", 32'(dut.credit_q[0]), 5);
      drive(1'b1, BODY, 16'h0204, 1'b0, 1'b1, 1'b0);
      step();
      check("sim_same_cnt0", 32'(dut.credit_q[0]), 5);
      check("sim_same_valid", 32'(bus.valid_o), 1);
      drive(1'b1, BODY, 16'h0205, 1'b0, 1'b1, 1'b1);
      step();
      check("sim_diff_cnt0", 32'(dut.credit_q[0]), 4);
      check("sim_diff_cnt1", 32'(dut.credit_q[1]), 1);
      check("sim_diff_error", 32'(bus.error_o), 0);
      drive(1'b1, BODY, 16'h0206, 1'b0, 1'b0, 1'b0);
      step();
      check("mid_cnt0", 32'(dut.credit_q[0]), 3);
      check("mid_state", 32'(dut.state_q[0]), ST_ACTIVE);

      // Asynchronous reset mid-packet with a flit in flight
      drive(1'b1, BODY, 16'h0207, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_cnt0", 32'(dut.credit_q[0]), 8);
      check("arst_cnt1", 32'(dut.credit_q[1]), 8);
      check("arst_state", 32'(dut.state_q[0]), ST_IDLE);
      check("arst_valid", 32'(bus.valid_o), 0);
      check("arst_flit", 32'(bus.flit_o), 0);
      check("arst_free", 32'(bus.vc_free_o), 2'b11);
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      step();
      check("arst_rel_valid", 32'(bus.valid_o), 0);

      // Credit overflow on VC1
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b1, 1'b1);
      step();
      check("ovf_cnt1", 32'(dut.credit_q[1]), 8);
      check("ovf_error", 32'(bus.error_o), 1);
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("ovf_error_clr", 32'(bus.error_o), 0);

      // BODY to IDLE VC0: forwarded, credit consumed, FSM stays IDLE
      drive(1'b1, BODY, 16'h0BAD, 1'b0, 1'b0, 1'b0);
      step();
      check("viol_valid", 32'(bus.valid_o), 1);
      check("viol_flit", 32'(bus.flit_o), 32'(mk(BODY, 16'h0BAD)));
      check("viol_cnt0", 32'(dut.credit_q[0]), 7);
      check("viol_error", 32'(bus.error_o), 1);
      check("viol_state", 32'(dut.state_q[0]), ST_IDLE);

      // Two violations in one cycle: TAIL to IDLE VC0 plus overflow on VC1
      drive(1'b1, TAIL, 16'h0C0C, 1'b0, 1'b1, 1'b1);
      step();
      check("multi_error", 32'(bus.error_o), 1);
      check("multi_cnt0", 32'(dut.credit_q[0]), 6);
      drive(1'b0, HEAD, 16'h0, 1'b0, 1'b0, 1'b0);
      step();
      check("multi_error_clr", 32'(bus.error_o), 0);
      check("multi_free", 32'(bus.vc_free_o), 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/output_port.md
OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 Parameter: VC_NUM, default 2, number of virtual channels on the outgoing link.
REQ-002 Parameter: BUFFER_SIZE, default 8, depth in flits of each downstream input-port VC buffer; initial credit count per VC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  crossbar presents a flit this cycle.
REQ-006 flit_i  input  flit_t  flit from crossbar; flit_label field is HEAD, BODY, TAIL or HEADTAIL (noc_params).
REQ-007 vc_i  input  $clog2(VC_NUM)  downstream VC targeted by flit_i.
REQ-008 credit_valid_i  input  1  downstream router returns one credit this cycle.
REQ-009 credit_vc_i  input  $clog2(VC_NUM)  VC of the returned credit.
REQ-010 valid_o  output  1  flit on link valid.
REQ-011 flit_o  output  flit_t  flit to downstream input port.
REQ-012 vc_o  output  $clog2(VC_NUM)  VC of flit_o.
REQ-013 credit_avail_o  output  VC_NUM  bit v high when credit count of VC v > 0; used by switch allocator.
REQ-014 vc_free_o  output  VC_NUM  bit v high when VC v is IDLE; used by VC allocator.
REQ-015 error_o  output  1  one-cycle pulse on protocol violation.

Function
REQ-016 One credit counter per VC, width $clog2(BUFFER_SIZE+1), range 0..BUFFER_SIZE.
REQ-017 Flit accepted when valid_i=1 and credit count of vc_i > 0; accepted flit appears on flit_o/vc_o with valid_o=1 exactly one cycle later (registered output).
REQ-018 valid_i=1 with zero credits on vc_i: flit dropped, valid_o=0 next cycle, credit count unchanged, error_o pulses next cycle.
REQ-019 valid_o=0 in any cycle following no accepted flit; flit_o/vc_o hold last value.
REQ-020 Accepted flit decrements credit count of vc_i by 1.
REQ-021 credit_valid_i increments credit count of credit_vc_i by 1.
REQ-022 Accept and credit return on same VC in same cycle: count unchanged; on different VCs: each updated independently.
REQ-023 Credit return to a VC already at BUFFER_SIZE (and no simultaneous accept on it): count held at BUFFER_SIZE, error_o pulses next cycle.
REQ-024 credit_avail_o and vc_free_o are combinational from registered state (no dependency on same-cycle inputs).
REQ-025 Per-VC FSM states: IDLE, ACTIVE, DRAINING.
REQ-026 IDLE -> ACTIVE on accepted HEAD; IDLE -> DRAINING on accepted HEADTAIL.
REQ-027 ACTIVE -> DRAINING on accepted TAIL; BODY keeps ACTIVE.
REQ-028 DRAINING -> IDLE when credit count equals BUFFER_SIZE after the cycle's update (same edge as final credit return).
REQ-029 HEADTAIL/TAIL sent with all credits already full is impossible (send consumes a credit); DRAINING always lasts at least one cycle.
REQ-030 Label violation (BODY/TAIL to IDLE VC; HEAD/HEADTAIL to ACTIVE or DRAINING VC): flit still forwarded and credit consumed, FSM unchanged, error_o pulses next cycle.
REQ-031 Multiple violations in one cycle produce a single error_o pulse.

Reset
REQ-032 rst=1 asynchronously forces: all credit counts = BUFFER_SIZE, all FSMs IDLE, valid_o=0, flit_o=0, vc_o=0, error_o=0.
REQ-033 Outputs after reset: credit_avail_o=all ones, vc_free_o=all ones.
REQ-034 Reset mid-packet discards in-flight flit and all credit/FSM state; no flit emitted in the cycle after reset release unless accepted that cycle.

Verification
REQ-035 Reset, then HEAD, BODY, TAIL on VC0 in consecutive cycles -> valid_o=1 on cycles 2-4 with same flits, VC0 credits 8->5, vc_free_o[0]=0 from cycle after HEAD.
REQ-036 Eight flits (HEAD, 6 BODY, TAIL) to VC1, no credit return -> credit_avail_o[1]=0 after eighth; ninth valid_i on VC1 -> dropped, error_o=1 one cycle, count stays 0.
REQ-037 HEADTAIL on VC0 then one credit return on VC0 -> state DRAINING then IDLE on return edge; vc_free_o[0] back to 1.
REQ-038 Same-cycle accept and credit return on VC0 at count 5 -> count stays 5; on VC0 accept and VC1 return -> VC0 4, VC1 +1.
REQ-039 Credit return on VC1 at count 8 -> count 8, error_o pulse; BODY on IDLE VC0 -> forwarded, VC0 count 7, error_o pulse, VC0 stays IDLE.
REQ-040 Assert rst mid-packet on VC0 at count 3 -> immediately count 8, IDLE, valid_o=0.
